// File: rtl/pc16.sv
// rtl/pc16.sv - 16-bit Hack program counter built from a priority chain of mux16 stages
`timescale 1ns/1ps

module mux16 #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  output logic [WIDTH-1:0] y
);
  assign y = sel ? b : a;
endmodule

module pc16 #(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic             inc,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic             wrap
);
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] inc_val;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] next_val;
  logic             wrap_next;

  // Carry out of the adder is kept only for the wrap flag.
  assign sum = {1'b0, out} + {{WIDTH{1'b0}}, 1'b1};

  mux16 #(.WIDTH(WIDTH)) u_mux_inc (
    .a   (out),
    .b   (sum[WIDTH-1:0]),
    .sel (inc),
    .y   (inc_val)
  );

  mux16 #(.WIDTH(WIDTH)) u_mux_load (
    .a   (inc_val),
    .b   (in),
    .sel (load),
    .y   (load_val)
  );

  mux16 #(.WIDTH(WIDTH)) u_mux_clr (
    .a   (load_val),
    .b   (RESET_VAL),
    .sel (clr),
    .y   (next_val)
  );

  assign wrap_next = inc & ~load & ~clr & sum[WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out  <= RESET_VAL;
      wrap <= 1'b0;
    end else begin
      out  <= next_val;
      wrap <= wrap_next;
    end
  end
endmodule

// File: tb/tb_pc16.sv
// tb/tb_pc16.sv - scoreboard bench for pc16: directed vectors plus a random run against a reference model
`timescale 1ns/1ps

module tb_pc16;
  logic        clk;
  logic        rst_n;
  logic        clr;
  logic        load;
  logic        inc;
  logic [15:0] in;
  logic [15:0] out;
  logic        wrap;

  typedef struct {
    logic [15:0] o;
    logic        w;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  logic [15:0] m_out;
  logic        m_wrap;

  pc16 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .load  (load),
    .inc   (inc),
    .in    (in),
    .out   (out),
    .wrap  (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] ao, input logic aw,
                       input logic [15:0] eo, input logic ew);
    checks++;
    if (ao !== eo || aw !== ew) begin
      errors++;
      $display("FAIL %s: got out=%h wrap=%b, expected out=%h wrap=%b", name, ao, aw, eo, ew);
    end
  endtask

  // Drive one cycle of controls at the falling edge and queue what the next rising edge must produce.
  task automatic step(input string name, input logic c, input logic l, input logic i,
                      input logic [15:0] d, input logic [15:0] eo, input logic ew);
    exp_t e;
    @(negedge clk);
    clr  = c;
    load = l;
    inc  = i;
    in   = d;
    e.o = eo;
    e.w = ew;
    e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic idle_ctrl();
    clr  = 1'b0;
    load = 1'b0;
    inc  = 1'b0;
  endtask

  // Monitor: one queued expectation per rising edge, compared just after the edge.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check(e.name, out, wrap, e.o, e.w);
    end
  end

  initial begin
    logic        rc, rl, ri;
    logic [15:0] rd;
    rst_n = 1'b0;
    clr   = 1'bx;
    load  = 1'bx;
    inc   = 1'bx;
    in    = 16'hxxxx;
    #12;
    check("reset_x_ctrl", out, wrap, 16'h0000, 1'b0);
    @(negedge clk);
    idle_ctrl();
    in = 16'h0000;
    rst_n = 1'b1;

    // 1: count to 5, async reset between edges, then count again
    for (int k = 1; k <= 5; k++) step("pre_count", 0, 0, 1, 16'h0, 16'(k), 0);
    @(negedge clk);
    idle_ctrl();
    #1 rst_n = 1'b0;
    #1 check("async_reset_mid_count", out, wrap, 16'h0000, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step("inc_after_reset_1", 0, 0, 1, 16'h0, 16'h0001, 0);
    step("inc_after_reset_2", 0, 0, 1, 16'h0, 16'h0002, 0);
    step("inc_after_reset_3", 0, 0, 1, 16'h0, 16'h0003, 0);

    // 2: load, increment, hold
    step("load_1234", 0, 1, 0, 16'h1234, 16'h1234, 0);
    step("inc_1235", 0, 0, 1, 16'h0, 16'h1235, 0);
    step("inc_1236", 0, 0, 1, 16'h0, 16'h1236, 0);
    for (int k = 0; k < 3; k++) step("hold_1236", 0, 0, 0, 16'hBEEF, 16'h1236, 0);

    // 3: rollover and single-cycle wrap pulse
    step("load_fffe", 0, 1, 0, 16'hFFFE, 16'hFFFE, 0);
    step("inc_ffff", 0, 0, 1, 16'h0, 16'hFFFF, 0);
    step("inc_wrap", 0, 0, 1, 16'h0, 16'h0000, 1);
    step("wrap_clears", 0, 0, 0, 16'h0, 16'h0000, 0);

    // 4: priority
    step("load_ffff", 0, 1, 0, 16'hFFFF, 16'hFFFF, 0);
    step("clr_beats_all", 1, 1, 1, 16'hAAAA, 16'h0000, 0);
    step("load_beats_inc", 0, 1, 1, 16'h5555, 16'h5555, 0);
    step("load_ffff_2", 0, 1, 0, 16'hFFFF, 16'hFFFF, 0);
    step("load_inc_no_wrap", 0, 1, 1, 16'h0010, 16'h0010, 0);

    // 5: 3 ns async reset pulse with a load pending
    @(negedge clk);
    clr = 1'b0; load = 1'b1; inc = 1'b0; in = 16'hFFFF;
    #1 rst_n = 1'b0;
    #1 check("async_reset_during", out, wrap, 16'h0000, 1'b0);
    #2 rst_n = 1'b1;
    #0 check("async_reset_after", out, wrap, 16'h0000, 1'b0);
    begin
      exp_t e;
      e.o = 16'hFFFF;
      e.w = 1'b0;
      e.name = "load_after_release";
      exp_q.push_back(e);
    end

    // 6: random traffic against a behavioural model, starting from a clear
    step("rand_start_clr", 1, 0, 0, 16'h0, 16'h0000, 0);
    m_out = 16'h0000;
    for (int k = 0; k < 1000; k++) begin
      rc = ($urandom_range(0, 15) == 0);
      rl = ($urandom_range(0, 5) == 0);
      ri = $urandom_range(0, 1) == 1;
      rd = ($urandom_range(0, 3) == 0) ? 16'hFFFD + 16'($urandom_range(0, 2)) : 16'($urandom);
      if (rc) begin
        m_out = 16'h0000; m_wrap = 1'b0;
      end else if (rl) begin
        m_out = rd; m_wrap = 1'b0;
      end else if (ri) begin
        m_wrap = (m_out == 16'hFFFF);
        m_out = m_out + 16'h0001;
      end else begin
        m_wrap = 1'b0;
      end
      step("random", rc, rl, ri, rd, m_out, m_wrap);
    end

    @(negedge clk);
    idle_ctrl();
    repeat (4) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end
endmodule
